// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential 24x24 multiplier.
package mult_pkg;

    localparam int WIDTH = 24;
    localparam int HALF  = WIDTH / 2;

    localparam logic [5:0] SH0 = 6'd0;
    localparam logic [5:0] SH1 = 6'd12;
    localparam logic [5:0] SH2 = 6'd12;
    localparam logic [5:0] SH3 = 6'd24;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    function automatic logic [5:0] step_shift(input logic [1:0] step);
        return step == 2'd0 ? SH0 :
               step == 2'd1 ? SH1 :
               step == 2'd2 ? SH2 : SH3;
    endfunction

endpackage

// File: rtl/mult12.sv
// mult12: combinational 12x12 unsigned multiplier core.
module mult12 (
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic [23:0] p
);

    assign p = {12'd0, a} * {12'd0, b};

endmodule

// File: rtl/mult24_seq.sv
// mult24_seq: 24x24 unsigned multiplier sharing one mult12 core over four cycles.
module mult24_seq
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     a_r, b_r;
    logic [2*WIDTH-1:0]   acc;
    logic [1:0]           step;
    logic [HALF-1:0]      op_a, op_b;
    logic [2*HALF-1:0]    pp;
    logic [2*WIDTH-1:0]   pp_sh;
    logic                 accept;

    // step[1] picks the high half of a, step[0] the high half of b
    assign op_a  = step[1] ? a_r[WIDTH-1:HALF] : a_r[HALF-1:0];
    assign op_b  = step[0] ? b_r[WIDTH-1:HALF] : b_r[HALF-1:0];
    assign pp_sh = {{WIDTH{1'b0}}, pp} << step_shift(step);

    mult12 u_mult12 (
        .a(op_a),
        .b(op_b),
        .p(pp)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (step == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? MUL : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign product = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            acc  <= '0;
            step <= '0;
        end else if (accept) begin
            a_r  <= a;
            b_r  <= b;
            acc  <= '0;
            step <= '0;
        end else if (state == MUL) begin
            acc  <= acc + pp_sh;
            step <= step + 2'd1;
        end
    end

endmodule

// File: tb/tb_mult24_seq.sv
// tb_mult24_seq: table-driven and scoreboarded bench for mult24_seq.
module tb_mult24_seq;
    import mult_pkg::*;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [23:0] a = '0;
    logic [23:0] b = '0;
    logic        in_ready, out_valid, busy;
    logic [47:0] product;

    int          n_vec = 0;
    int          n_err = 0;
    logic [47:0] sb[$];

    always #5 clk = ~clk;

    mult24_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product(product),
        .busy(busy)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on an output handshake, push on an input handshake
    always @(negedge clk) begin
        if (!rst_n) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: product %h with nothing expected", product);
                end else check("sb_product", product, sb.pop_front());
            end
            if (in_valid && in_ready) sb.push_back({24'd0, a} * {24'd0, b});
        end
    end

    task automatic run_op(input logic [23:0] xa, input logic [23:0] xb,
                          output logic [47:0] res, output int lat, output int bc);
        int w;
        w   = 0;
        res = '0;
        lat = 0;
        bc  = 0;
        @(posedge clk); #1;
        a = xa;
        b = xb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            bc += int'(busy);
        end
        res = product;
        @(posedge clk); #1;
    endtask

    vec_t        tbl[9];
    vec_t        pr[3];
    logic [47:0] res;
    int          lat, bc, cnt, idx, nout;
    int          t[3];
    logic        acc_now;

    initial begin
        tbl[0] = '{24'h123456, 24'h000002, 48'h0000002468AC};
        tbl[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
        tbl[2] = '{24'h001000, 24'h001000, 48'h000001000000};
        tbl[3] = '{24'h000000, 24'hABCDEF, 48'h000000000000};
        tbl[4] = '{24'hABCDEF, 24'h000010, 48'h00000ABCDEF0};
        tbl[5] = '{24'h800000, 24'h800000, 48'h400000000000};
        tbl[6] = '{24'hFFF000, 24'h000FFF, 48'h000FFE001000};
        tbl[7] = '{24'h000FFF, 24'hFFF000, 48'h000FFE001000};
        tbl[8] = '{24'h000001, 24'hFFFFFF, 48'h000000FFFFFF};

        repeat (2) @(negedge clk);
        check("rst_in_ready", {47'd0, in_ready}, 48'd1);
        check("rst_out_valid", {47'd0, out_valid}, 48'd0);
        check("rst_busy", {47'd0, busy}, 48'd0);
        check("rst_product", product, 48'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].a, tbl[i].b, res, lat, bc);
            check($sformatf("tbl%0d_product", i), res, tbl[i].p);
            check($sformatf("tbl%0d_latency", i), 48'(lat), 48'd4);
            check($sformatf("tbl%0d_busy", i), 48'(bc), 48'd4);
        end

        for (int i = 0; i < 6; i++)
            run_op(24'($urandom), 24'($urandom), res, lat, bc);

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        run_op(24'h001000, 24'h001000, res, lat, bc);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_valid", {47'd0, out_valid}, 48'd1);
            check("hold_product", product, 48'h000001000000);
            check("hold_in_ready", {47'd0, in_ready}, 48'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("release_out_valid", {47'd0, out_valid}, 48'd0);
        check("release_in_ready", {47'd0, in_ready}, 48'd1);

        // Back-to-back stream
        pr[0] = tbl[0];
        pr[1] = tbl[1];
        pr[2] = tbl[6];
        @(posedge clk); #1;
        a = pr[0].a;
        b = pr[0].b;
        in_valid = 1'b1;
        idx = 0;
        nout = 0;
        for (int c = 0; c < 40 && nout < 3; c++) begin
            @(negedge clk);
            if (out_valid) begin
                t[nout] = c;
                check($sformatf("b2b%0d_product", nout), product, pr[nout].p);
                nout++;
            end
            acc_now = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc_now) begin
                idx++;
                if (idx < 3) begin
                    a = pr[idx].a;
                    b = pr[idx].b;
                end else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_count", 48'(nout), 48'd3);
        check("b2b_gap01", 48'(t[1] - t[0]), 48'd5);
        check("b2b_gap12", 48'(t[2] - t[1]), 48'd5);

        // in_valid during MUL must be ignored
        a = 24'h000003;
        b = 24'h000005;
        in_valid = 1'b1;
        @(posedge clk); #1;
        a = 24'hABCDEF;
        b = 24'h000010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("ignore_product", product, 48'd15);
        @(posedge clk); #1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cnt += int'(out_valid);
        end
        check("ignore_no_extra", 48'(cnt), 48'd0);

        // Reset during MUL step 2
        @(posedge clk); #1;
        a = 24'hFFFFFF;
        b = 24'hFFFFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_busy", {47'd0, busy}, 48'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {47'd0, out_valid}, 48'd0);
        check("mid_rst_product", product, 48'd0);
        check("mid_rst_busy", {47'd0, busy}, 48'd0);
        check("mid_rst_in_ready", {47'd0, in_ready}, 48'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt += int'(out_valid);
        end
        check("mid_rst_no_result", 48'(cnt), 48'd0);
        check("sb_drained", 48'(sb.size()), 48'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
